fcc_result_packer: RTL and testbench
====================================

// Module: fcc_result_packer
// PURPOSE
//  Downstream stage of the fcc engine. Accepts signed accumulator results (dot product plus bias), one per neuron.
//  Requantizes each result to int8 (round, optional ReLU, saturate) and packs 32 bytes per memory line.
//  Writes each line to the fcc return window starting at fc_addrz, using a req/ack write handshake.
//  Pulses done once all results of a layer have been written and acknowledged.
// PARAMETERS
//  ADDR_WIDTH  19  byte address width of the memory write request
//  ACC_W       24  width of the signed accumulator result
//  CNT_W        8  width of the result-count field (max 255 results per layer)
//  LINE_BYTES  32  bytes per memory line; fixed at 32 (bus is 256 bits)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  cfg_go         in   1           start pulse; samples all cfg_* inputs
//  cfg_addrz      in   ADDR_WIDTH  base byte address of the output vector
//  cfg_num_res    in   CNT_W       number of results in this layer
//  cfg_shift      in   5           requant arithmetic right shift (0..23)
//  cfg_relu       in   1           1: negative results are clamped to 0
//  res_valid      in   1           result available from the fcc
//  res_data       in   ACC_W       signed result
//  res_ready      out  1           packer can accept a result
//  wr_req         out  1           line write request
//  wr_start_addr  out  ADDR_WIDTH  byte address of the line
//  wr_size_bytes  out  6           valid bytes in the line (1..32)
//  wr_last_valid  out  5           index of the last valid byte (wr_size_bytes-1)
//  wr_data        out  256         packed bytes; byte k occupies [8k+7:8k]
//  wr_ack         in   1           memory accepted the line
//  busy           out  1           high from the cycle after an accepted cfg_go until done
//  done           out  1           single-cycle pulse when the layer is complete
// BEHAVIOUR
//  Reset: all outputs are 0, the FSM is in IDLE, and the byte buffer, byte counter, result counter and address are cleared.
//    Reset asserted mid-layer (including during WRITE) aborts the layer. No done pulse is generated.
//  FSM: IDLE -> COLLECT -> WRITE -> (COLLECT | FIN) -> IDLE.
//  IDLE: cfg_go=1 latches the cfg_* inputs, sets addr=cfg_addrz and clears the counters.
//    If cfg_num_res=0, go to FIN and write nothing. Otherwise go to COLLECT.
//  cfg_go outside IDLE is ignored.
//  COLLECT: res_ready=1. A result is accepted on res_valid&&res_ready.
//    The requantized byte goes into buffer slot byte_cnt, then byte_cnt and res_cnt increment.
//    Go to WRITE when byte_cnt reaches 32 or res_cnt reaches cfg_num_res.
//    The next cycle then presents wr_req=1, so write latency is 1 cycle after the accepting edge.
//  Requant: if shift>0, t = (x + (1<<(shift-1))) >>> shift (round half up). If shift=0, t = x.
//    Compute at ACC_W+1 bits so the rounding add cannot overflow.
//    If cfg_relu and t<0, t = 0.
//    Saturate: t>127 gives 127; t<-128 gives -128.
//  WRITE: res_ready=0, and wr_req, wr_data, wr_start_addr and the size fields are held stable until wr_ack=1 is sampled.
//    Buffer bytes at index byte_cnt and above are driven as 0.
//    wr_ack is only honoured while wr_req=1. wr_ack=1 in the first wr_req cycle is legal, and wr_req drops the next cycle.
//    On ack: addr += 32, byte_cnt = 0, and the buffer is cleared.
//    If res_cnt < cfg_num_res, go to COLLECT. Otherwise go to FIN.
//  FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
//  No back-to-back requests: there is at least one cycle with wr_req=0 between two lines.
//  Address arithmetic wraps modulo 2^ADDR_WIDTH and needs no special handling.
// TESTING
//  1) addrz=0x100, num_res=32, shift=0, relu=0, res 0..31 back-to-back, ack after 3 cycles.
//     -> one request: addr 0x100, size 32, last_valid 31, byte k = k. Then a done pulse.
//  2) num_res=40, ack immediate.
//     -> two requests: addr base with size 32, then base+32 with size 8, last_valid 7, bytes 8..31 = 0.
//  3) shift=4, relu=0, results 24, 23, -24, 5000, -5000.
//     -> bytes 2, 1, -1 (0xFF), 127, -128 (0x80).
//  4) relu=1, shift=0, results -1, -300, 7.
//     -> bytes 0, 0, 7. Size 3.
//  5) cfg_go pulsed again while busy, with a different addrz.
//     -> ignored; addresses follow the first config.
//     cfg_num_res=0 -> no wr_req, done pulses exactly one cycle after the go.
//  6) Assert rst_n=0 while wr_req=1 and hold ack low.
//     -> wr_req, busy and done are 0 immediately. A new go restarts from cfg_addrz.

Source files
------------

// File: rtl/fcc_result_packer.sv
// Requantizes fcc accumulator results to int8, packs them into 32-byte lines and
// writes each line to the return window with a req/ack handshake.
module fcc_result_packer #(
    parameter int ADDR_WIDTH = 19,
    parameter int ACC_W      = 24,
    parameter int CNT_W      = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_go,
    input  logic [ADDR_WIDTH-1:0] cfg_addrz,
    input  logic [CNT_W-1:0]      cfg_num_res,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic                  res_valid,
    input  logic [ACC_W-1:0]      res_data,
    output logic                  res_ready,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_start_addr,
    output logic [5:0]            wr_size_bytes,
    output logic [4:0]            wr_last_valid,
    output logic [255:0]          wr_data,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = $clog2(LINE_BYTES);
    localparam int BC_W  = IDX_W + 1;
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;

    state_t                         state, state_nxt;
    logic [ADDR_WIDTH-1:0]          addr;
    logic [BC_W-1:0]                byte_cnt, byte_cnt_inc;
    logic [CNT_W-1:0]               res_cnt, res_cnt_inc, num_res;
    logic [4:0]                     shift;
    logic                           relu;
    logic [LINE_BYTES-1:0][7:0]     line_buf;
    logic                           accept, ack;
    logic signed [ACC_W:0]          x_ext, rnd, t;
    logic [7:0]                     q_byte;

    assign res_ready    = (state == COLLECT);
    assign wr_req       = (state == WRITE);
    assign busy         = (state == COLLECT) || (state == WRITE);
    assign done         = (state == FIN);
    assign accept       = res_valid && res_ready;
    assign ack          = wr_ack && wr_req;
    assign byte_cnt_inc = byte_cnt + BC_W'(1);
    assign res_cnt_inc  = res_cnt + CNT_W'(1);

    // One extra bit of headroom keeps the round-half-up add from overflowing.
    always_comb begin
        x_ext = $signed({res_data[ACC_W-1], res_data});
        rnd   = '0;
        if (shift != 5'd0)
            rnd[shift - 5'd1] = 1'b1;
        t = (x_ext + rnd) >>> shift;
        if (relu && t[ACC_W])
            q_byte = 8'h00;
        else if (t > Q_MAX)
            q_byte = 8'h7F;
        else if (t < Q_MIN)
            q_byte = 8'h80;
        else
            q_byte = t[7:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_go)
                         state_nxt = (cfg_num_res == '0) ? FIN : COLLECT;
            COLLECT: if (accept && (byte_cnt_inc == BC_W'(LINE_BYTES) || res_cnt_inc == num_res))
                         state_nxt = WRITE;
            WRITE:   if (ack)
                         state_nxt = (res_cnt < num_res) ? COLLECT : FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            byte_cnt <= '0;
            res_cnt  <= '0;
            num_res  <= '0;
            shift    <= '0;
            relu     <= 1'b0;
            line_buf <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cfg_go) begin
                    addr     <= cfg_addrz;
                    num_res  <= cfg_num_res;
                    shift    <= cfg_shift;
                    relu     <= cfg_relu;
                    byte_cnt <= '0;
                    res_cnt  <= '0;
                    line_buf <= '0;
                end
                COLLECT: if (accept) begin
                    line_buf[byte_cnt[IDX_W-1:0]] <= q_byte;
                    byte_cnt <= byte_cnt_inc;
                    res_cnt  <= res_cnt_inc;
                end
                WRITE: if (ack) begin
                    addr     <= addr + ADDR_WIDTH'(LINE_BYTES);
                    byte_cnt <= '0;
                    line_buf <= '0;
                end
                default: ;
            endcase
        end
    end

    // Unused buffer slots are already zero because the buffer clears after every line.
    always_comb begin
        wr_start_addr = '0;
        wr_size_bytes = '0;
        wr_last_valid = '0;
        wr_data       = '0;
        if (wr_req) begin
            wr_start_addr = addr;
            wr_size_bytes = 6'(byte_cnt);
            wr_last_valid = 5'(byte_cnt - BC_W'(1));
            wr_data       = line_buf;
        end
    end
endmodule

// File: tb/tb_fcc_result_packer.sv
// Self-checking bench for fcc_result_packer: vector table, directed corner cases and
// randomized layers scored against a plain-arithmetic requant/packing model.
module tb_fcc_result_packer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_go = 1'b0;
    logic [18:0]  cfg_addrz = '0;
    logic [7:0]   cfg_num_res = '0;
    logic [4:0]   cfg_shift = '0;
    logic         cfg_relu = 1'b0;
    logic         res_valid = 1'b0;
    logic [23:0]  res_data = '0;
    logic         res_ready;
    logic         wr_req;
    logic [18:0]  wr_start_addr;
    logic [5:0]   wr_size_bytes;
    logic [4:0]   wr_last_valid;
    logic [255:0] wr_data;
    logic         wr_ack = 1'b0;
    logic         busy;
    logic         done;

    int n_chk = 0;
    int n_fail = 0;
    int vals[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int         lay;
        int         sh;
        bit         rl;
        int         x;
        logic [7:0] e;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fcc_result_packer dut (
        .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go), .cfg_addrz(cfg_addrz),
        .cfg_num_res(cfg_num_res), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .wr_req(wr_req), .wr_start_addr(wr_start_addr), .wr_size_bytes(wr_size_bytes),
        .wr_last_valid(wr_last_valid), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int lay, int sh, bit rl, int x, logic [7:0] e);
        mk.lay = lay; mk.sh = sh; mk.rl = rl; mk.x = x; mk.e = e;
    endfunction

    // floor((x + 2^(sh-1)) / 2^sh), optional relu, clamp to [-128,127]
    function automatic logic [7:0] model_rq(int x, int sh, bit rl);
        longint t;
        t = x;
        if (sh > 0) t = (t + (longint'(1) << (sh - 1))) >>> sh;
        if (rl && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    // Runs one layer from vals[], expecting bytes exp_q[] in 32-byte lines from az.
    task automatic run_layer(input logic [18:0] az, input int sh, input bit rl,
                             input int ack_dly, input bit gaps, input bit regos);
        int n;
        int nl;
        n  = vals.size();
        nl = (n + 31) / 32;
        @(negedge clk);
        cfg_go = 1'b1; cfg_addrz = az; cfg_num_res = 8'(n);
        cfg_shift = 5'(sh); cfg_relu = rl;
        @(negedge clk);
        cfg_go = 1'b0;
        if (n == 0) begin
            chk("empty_done", done, 1'b1);
            chk("empty_noreq", {wr_req, busy}, 2'b00);
            @(negedge clk);
            chk("empty_done_once", {done, wr_req}, 2'b00);
            return;
        end
        chk("busy_after_go", {busy, done}, 2'b10);
        fork
            begin : feed
                int i;
                int cyc;
                i = 0; cyc = 0;
                while (i < n && cyc < 4000) begin
                    if (gaps && $urandom_range(0, 2) == 0) res_valid = 1'b0;
                    else begin
                        res_valid = 1'b1;
                        res_data  = 24'(vals[i]);
                        if (res_ready) i++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                res_valid = 1'b0;
                if (i < n) chk("feed_timeout", 32'(i), 32'(n));
            end
            begin : wr
                for (int l = 0; l < nl; l++) begin
                    logic [255:0] e;
                    logic [299:0] snap;
                    logic [18:0]  ea;
                    int cyc;
                    int sz;
                    cyc = 0;
                    while (!wr_req && cyc < 4000) begin @(negedge clk); cyc++; end
                    if (!wr_req) begin chk("wr_timeout", 1'b0, 1'b1); break; end
                    sz = (n - 32*l > 32) ? 32 : n - 32*l;
                    e = '0;
                    for (int j = 0; j < sz; j++) e[8*j +: 8] = exp_q[32*l + j];
                    ea = az + 19'(32*l);
                    chk("wr_addr", wr_start_addr, ea);
                    chk("wr_size", {wr_size_bytes, wr_last_valid}, {6'(sz), 5'(sz - 1)});
                    chk("wr_data", wr_data, e);
                    snap = {wr_req, wr_start_addr, wr_size_bytes, wr_data};
                    repeat (ack_dly) begin
                        @(negedge clk);
                        chk("wr_hold", {wr_req, wr_start_addr, wr_size_bytes, wr_data}, snap);
                    end
                    wr_ack = 1'b1;
                    @(negedge clk);
                    wr_ack = 1'b0;
                    chk("wr_gap", wr_req, 1'b0);
                    if (l == nl - 1) begin
                        chk("done_pulse", {done, busy}, 2'b10);
                        @(negedge clk);
                        chk("done_once", {done, busy, wr_req}, 3'b000);
                    end
                end
            end
            begin : rego
                if (regos) begin
                    repeat (3) @(negedge clk);
                    cfg_go = 1'b1; cfg_addrz = ~az; cfg_num_res = 8'd0;
                    @(negedge clk);
                    cfg_go = 1'b0;
                end
            end
        join
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lay, sh, rn, r, cyc;
        bit rl;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {wr_req, busy, done, res_ready, wr_start_addr, wr_size_bytes,
                              wr_last_valid, wr_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 32 results, one full line, delayed ack
        vals.delete(); exp_q.delete();
        for (int i = 0; i < 32; i++) begin vals.push_back(i); exp_q.push_back(8'(i)); end
        run_layer(19'h00100, 0, 1'b0, 3, 1'b0, 1'b0);

        // 40 results, immediate ack, second line wraps the address space
        vals.delete(); exp_q.delete();
        for (int i = 0; i < 40; i++) begin vals.push_back(i); exp_q.push_back(8'(i)); end
        run_layer(19'h7FFF0, 0, 1'b0, 0, 1'b0, 1'b0);

        // requant vectors, grouped into layers by lay
        tbl.push_back(mk(0, 4, 1'b0, 24, 8'h02));
        tbl.push_back(mk(0, 4, 1'b0, 23, 8'h01));
        tbl.push_back(mk(0, 4, 1'b0, -24, 8'hFF));
        tbl.push_back(mk(0, 4, 1'b0, 5000, 8'h7F));
        tbl.push_back(mk(0, 4, 1'b0, -5000, 8'h80));
        tbl.push_back(mk(1, 0, 1'b1, -1, 8'h00));
        tbl.push_back(mk(1, 0, 1'b1, -300, 8'h00));
        tbl.push_back(mk(1, 0, 1'b1, 7, 8'h07));
        tbl.push_back(mk(2, 0, 1'b0, 127, 8'h7F));
        tbl.push_back(mk(2, 0, 1'b0, 128, 8'h7F));
        tbl.push_back(mk(2, 0, 1'b0, -128, 8'h80));
        tbl.push_back(mk(2, 0, 1'b0, -129, 8'h80));
        tbl.push_back(mk(2, 0, 1'b0, 0, 8'h00));
        tbl.push_back(mk(3, 1, 1'b0, 1, 8'h01));
        tbl.push_back(mk(3, 1, 1'b0, -1, 8'h00));
        tbl.push_back(mk(3, 1, 1'b0, -3, 8'hFF));
        tbl.push_back(mk(3, 1, 1'b0, 3, 8'h02));
        tbl.push_back(mk(4, 23, 1'b0, 8388607, 8'h01));
        tbl.push_back(mk(4, 23, 1'b0, -8388608, 8'hFF));
        tbl.push_back(mk(4, 23, 1'b0, 4194303, 8'h00));
        tbl.push_back(mk(4, 23, 1'b0, 4194304, 8'h01));
        tbl.push_back(mk(5, 23, 1'b1, -8388608, 8'h00));
        tbl.push_back(mk(6, 8, 1'b0, 32767, 8'h7F));
        tbl.push_back(mk(6, 8, 1'b0, 32639, 8'h7F));
        tbl.push_back(mk(6, 8, 1'b0, -32768, 8'h80));
        tbl.push_back(mk(6, 8, 1'b0, -32897, 8'h80));
        k = 0;
        while (k < tbl.size()) begin
            lay = tbl[k].lay; sh = tbl[k].sh; rl = tbl[k].rl;
            vals.delete(); exp_q.delete();
            while (k < tbl.size() && tbl[k].lay == lay) begin
                vals.push_back(tbl[k].x); exp_q.push_back(tbl[k].e); k++;
            end
            run_layer(19'h01000 + 19'(lay * 64), sh, rl, lay % 3, 1'b0, 1'b0);
        end

        // cfg_go while busy is ignored
        vals.delete(); exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            r = $signed($urandom) >>> 16;
            vals.push_back(r); exp_q.push_back(model_rq(r, 2, 1'b0));
        end
        run_layer(19'h04000, 2, 1'b0, 2, 1'b1, 1'b1);

        // empty layer
        vals.delete(); exp_q.delete();
        run_layer(19'h05000, 0, 1'b0, 0, 1'b0, 1'b0);

        // reset during an unacknowledged write
        @(negedge clk);
        cfg_go = 1'b1; cfg_addrz = 19'h00600; cfg_num_res = 8'd32; cfg_shift = 5'd0; cfg_relu = 1'b0;
        @(negedge clk);
        cfg_go = 1'b0;
        for (int i = 0; i < 32; i++) begin
            res_valid = 1'b1; res_data = 24'(i);
            @(negedge clk);
        end
        res_valid = 1'b0;
        cyc = 0;
        while (!wr_req && cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst_pre_req", wr_req, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_abort", {wr_req, busy, done, res_ready}, 4'b0000);
        @(negedge clk);
        chk("rst_no_done", {wr_req, busy, done}, 3'b000);
        rst_n = 1'b1;
        vals.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin vals.push_back(i * 3 - 6); exp_q.push_back(8'(i * 3 - 6)); end
        run_layer(19'h00700, 0, 1'b0, 1, 1'b0, 1'b0);

        // randomized layers
        repeat (12) begin
            rn = $urandom_range(0, 90);
            sh = $urandom_range(0, 23);
            rl = 1'($urandom_range(0, 1));
            vals.delete(); exp_q.delete();
            for (int i = 0; i < rn; i++) begin
                r = $signed($urandom) >>> (8 + $urandom_range(0, 20));
                vals.push_back(r); exp_q.push_back(model_rq(r, sh, rl));
            end
            run_layer(19'($urandom), sh, rl, $urandom_range(0, 4), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
